// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: decodes NEC IR frames and repeat codes into a 32-bit word and a held button mask
module nec_ir_decoder #(
  parameter int         TICK_DIV   = 1,
  parameter int         HOLD_US    = 110000,
  parameter logic [7:0] CMD_BASE   = 8'h40,
  parameter int         TIME_SCALE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        frame_valid,
  output logic        repeat_det,
  output logic        frame_err,
  output logic [7:0]  ir_mux
);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK, RPT_MARK} state_t;
  localparam int LM_LO = 8000 / TIME_SCALE;
  localparam int LM_HI = 10000 / TIME_SCALE;
  localparam int LS_LO = 4000 / TIME_SCALE;
  localparam int LS_HI = 5000 / TIME_SCALE;
  localparam int RS_LO = 1750 / TIME_SCALE;
  localparam int RS_HI = 2750 / TIME_SCALE;
  localparam int BM_LO = 300 / TIME_SCALE;
  localparam int BM_HI = 800 / TIME_SCALE;
  localparam int B1_LO = 1400 / TIME_SCALE;
  localparam int B1_HI = 1900 / TIME_SCALE;
  state_t state, state_n;
  logic s1, s2, mark, mark_d, chg, tick, tout;
  logic fv_n, rp_n, fe_n, pass, bm_ok, one_ok, ls_d, ls_r;
  logic [15:0] div;
  logic [16:0] cnt, hold;
  logic [31:0] sr, sr_n;
  logic [5:0] nbit, nbit_n;
  logic [7:0] off, cmd_mask;
  int max_w;
  function automatic logic in_win(input logic [16:0] w, input int lo, input int hi);
    return int'(w) >= lo && int'(w) <= hi;
  endfunction
  assign mark     = ~s2;
  assign chg      = mark ^ mark_d;
  assign tick     = div == 16'(TICK_DIV - 1);
  assign bm_ok    = in_win(cnt, BM_LO, BM_HI);
  assign one_ok   = in_win(cnt, B1_LO, B1_HI);
  assign ls_d     = in_win(cnt, LS_LO, LS_HI);
  assign ls_r     = in_win(cnt, RS_LO, RS_HI);
  assign pass     = (sr[23:16] ^ sr[31:24]) == 8'hFF;
  assign off      = sr[23:16] - CMD_BASE;
  assign cmd_mask = off < 8'd8 ? 8'd1 << off[2:0] : 8'h00;
  assign max_w    = state == LEAD_MARK ? LM_HI : state == LEAD_SPACE ? LS_HI : state == BIT_SPACE ? B1_HI : BM_HI;
  assign tout     = state != IDLE && state != CHECK && int'(cnt) > max_w;
  // synchroniser, us tick divider and saturating level-width counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      mark_d <= 1'b0;
      div    <= '0;
      cnt    <= '0;
    end else begin
      s1     <= ir_in;
      s2     <= s1;
      mark_d <= mark;
      div    <= tick ? '0 : div + 16'd1;
      cnt    <= chg ? '0 : (tick && !(&cnt)) ? cnt + 17'd1 : cnt;
    end
  // FSM state, shift register and bit counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      nbit  <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      nbit  <= nbit_n;
    end
  // next state: widths are judged at the edge ending each level, overruns abort at once
  always_comb begin
    state_n = state;
    sr_n    = sr;
    nbit_n  = nbit;
    fv_n    = 1'b0;
    rp_n    = 1'b0;
    fe_n    = 1'b0;
    if (tout) begin
      state_n = IDLE;
      fe_n    = 1'b1;
    end else if (state == CHECK) begin
      state_n = IDLE;
      fv_n    = pass;
      fe_n    = !pass;
    end else if (chg) begin
      case (state)
        IDLE:       state_n = mark ? LEAD_MARK : IDLE;
        LEAD_MARK:  state_n = int'(cnt) >= LM_LO ? LEAD_SPACE : IDLE;
        LEAD_SPACE: begin
          state_n = ls_d ? BIT_MARK : ls_r ? RPT_MARK : IDLE;
          fe_n    = !(ls_d || ls_r);
          nbit_n  = '0;
        end
        BIT_MARK: begin
          state_n = bm_ok ? BIT_SPACE : IDLE;
          fe_n    = !bm_ok;
        end
        BIT_SPACE: begin
          sr_n    = {one_ok, sr[31:1]};
          nbit_n  = nbit + 6'd1;
          state_n = !(bm_ok || one_ok) ? IDLE : nbit == 6'd31 ? STOP_MARK : BIT_MARK;
          fe_n    = !(bm_ok || one_ok);
        end
        STOP_MARK: begin
          state_n = bm_ok ? CHECK : IDLE;
          fe_n    = !bm_ok;
        end
        RPT_MARK: begin
          state_n = IDLE;
          rp_n    = bm_ok && hold != '0;
          fe_n    = !bm_ok;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // registered pulses, frame word, hold timer and button mask; a committed frame beats hold expiry
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      frame_valid <= 1'b0;
      repeat_det  <= 1'b0;
      frame_err   <= 1'b0;
      ir_data     <= '0;
      ir_mux      <= '0;
      hold        <= '0;
    end else begin
      frame_valid <= fv_n;
      repeat_det  <= rp_n;
      frame_err   <= fe_n;
      ir_data     <= fv_n ? sr : ir_data;
      hold        <= (fv_n || rp_n) ? 17'(HOLD_US) : (tick && hold != '0) ? hold - 17'd1 : hold;
      ir_mux      <= fv_n ? cmd_mask : (tick && hold == 17'd1 && !rp_n) ? 8'h00 : ir_mux;
    end
endmodule
